// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector. A KMP-style prefix-length register is advanced from a
// transition table that is built from PATTERN at elaboration time. A saturating match counter sits beside it.
module seq_detector_param #(
   parameter int                 PAT_LEN = 4,
   parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
   parameter bit                 OVERLAP = 1'b1,
   parameter bit                 MOORE   = 1'b0,
   parameter int                 CNT_W   = 8,
   localparam int                SW      = (PAT_LEN > 2) ? $clog2(PAT_LEN) : 1
) (
   input  logic             clk,
   input  logic             sync_reset,
   input  logic             in_stream,
   input  logic             in_valid,
   input  logic             cnt_clr,
   output logic [SW-1:0]    state,
   output logic             out,
   output logic [CNT_W-1:0] match_cnt
);

   if (PAT_LEN < 2 || PAT_LEN > 16) begin : g_bad_len
      $error("seq_detector_param: PAT_LEN must lie in 2..16");
   end

   // Longest j <= limit such that the first j pattern bits equal the tail of
   // (first k pattern bits followed by b). Pattern bit i in arrival order is PATTERN[PAT_LEN-1-i].
   function automatic int longest_fix(input int k, input logic b, input int limit);
      int   best;
      int   si;
      logic ok;
      logic sb;
      best = 0;
      for (int j = 1; j <= PAT_LEN; j++) begin
         ok = (j <= k + 1) && (j <= limit);
         if (ok) begin
            for (int i = 0; i < PAT_LEN; i++) begin
               if (i < j) begin
                  si = k + 1 - j + i;
                  sb = (si == k) ? b : PATTERN[PAT_LEN-1-si];
                  if (sb != PATTERN[PAT_LEN-1-i]) ok = 1'b0;
               end
            end
         end
         if (ok) best = j;
      end
      return best;
   endfunction

   localparam int BORDER = longest_fix(PAT_LEN - 1, PATTERN[0], PAT_LEN - 1);
   localparam int NTAB   = 2 ** (SW + 1);

   logic [SW-1:0] nxt_tab [NTAB];

   for (genvar gk = 0; gk < 2 ** SW; gk++) begin : g_k
      for (genvar gb = 0; gb < 2; gb++) begin : g_b
         localparam int RAW = (gk < PAT_LEN) ? longest_fix(gk, (gb != 0), PAT_LEN) : 0;
         localparam int NXT = (RAW == PAT_LEN) ? (OVERLAP ? BORDER : 0) : RAW;
         assign nxt_tab[2*gk+gb] = SW'(NXT);
      end
   end

   logic [SW-1:0]    state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             moore_q, moore_d;
   logic             hit;
   logic             match;

   assign hit   = (state_q == SW'(PAT_LEN - 1)) && (in_stream == PATTERN[0]);
   assign match = in_valid & hit;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      moore_d = match;
      if (in_valid) state_d = nxt_tab[{state_q, in_stream}];
      // Clear beats a simultaneous match; the counter never wraps.
      if (cnt_clr)                    cnt_d = '0;
      else if (match && cnt_q != '1)  cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (sync_reset) begin
         state_q <= '0;
         cnt_q   <= '0;
         moore_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         moore_q <= moore_d;
      end
   end

   assign state     = state_q;
   assign match_cnt = cnt_q;
   assign out       = ~sync_reset & (MOORE ? moore_q : match);

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: five instances with different parameter sets share one
// input stream, and each scenario task checks the instances it targets.
module tb_seq_detector_param;

   logic clk;
   logic sync_reset;
   logic in_stream;
   logic in_valid;
   logic cnt_clr;

   logic [1:0] st_def, st_nov, st_moo, st_sat;
   logic [2:0] st_p6;
   logic       out_def, out_nov, out_moo, out_sat, out_p6;
   logic [7:0] cnt_def, cnt_nov, cnt_moo, cnt_p6;
   logic [1:0] cnt_sat;

   int n_vec = 0;
   int n_err = 0;

   seq_detector_param u_def (
      .clk(clk), .sync_reset(sync_reset), .in_stream(in_stream), .in_valid(in_valid),
      .cnt_clr(cnt_clr), .state(st_def), .out(out_def), .match_cnt(cnt_def));

   seq_detector_param #(.OVERLAP(1'b0)) u_nov (
      .clk(clk), .sync_reset(sync_reset), .in_stream(in_stream), .in_valid(in_valid),
      .cnt_clr(cnt_clr), .state(st_nov), .out(out_nov), .match_cnt(cnt_nov));

   seq_detector_param #(.MOORE(1'b1)) u_moo (
      .clk(clk), .sync_reset(sync_reset), .in_stream(in_stream), .in_valid(in_valid),
      .cnt_clr(cnt_clr), .state(st_moo), .out(out_moo), .match_cnt(cnt_moo));

   seq_detector_param #(.CNT_W(2)) u_sat (
      .clk(clk), .sync_reset(sync_reset), .in_stream(in_stream), .in_valid(in_valid),
      .cnt_clr(cnt_clr), .state(st_sat), .out(out_sat), .match_cnt(cnt_sat));

   seq_detector_param #(.PAT_LEN(6), .PATTERN(6'b110110)) u_p6 (
      .clk(clk), .sync_reset(sync_reset), .in_stream(in_stream), .in_valid(in_valid),
      .cnt_clr(cnt_clr), .state(st_p6), .out(out_p6), .match_cnt(cnt_p6));

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // drivers
   task automatic apply(input logic b, input logic v);
      @(negedge clk);
      in_stream = b;
      in_valid  = v;
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      sync_reset = 1'b1;
      in_valid   = 1'b0;
      in_stream  = 1'b0;
      cnt_clr    = 1'b0;
      repeat (n) @(posedge clk);
      @(negedge clk);
      sync_reset = 1'b0;
   endtask

   // scenarios
   task automatic test_reset();
      @(negedge clk);
      sync_reset = 1'b1;
      in_valid   = 1'b1;
      in_stream  = 1'b1;
      cnt_clr    = 1'b0;
      #1;
      n_vec++;
      if (out_def !== 1'b0) begin
         n_err++; $display("FAIL reset_mealy_out: got %b want 0", out_def);
      end
      repeat (5) @(posedge clk);
      #1;
      n_vec++;
      if (st_def !== 2'd0 || cnt_def !== 8'd0) begin
         n_err++; $display("FAIL reset_state: state %0d cnt %0d want 0 0", st_def, cnt_def);
      end
      n_vec++;
      if (out_moo !== 1'b0 || st_p6 !== 3'd0) begin
         n_err++; $display("FAIL reset_moore: out %b p6_state %0d want 0 0", out_moo, st_p6);
      end
      @(negedge clk);
      sync_reset = 1'b0;
      in_valid   = 1'b0;
   endtask

   task automatic test_basic();
      bit         s [14];
      int         es [14];
      logic       exp_o;
      s  = '{1,0,0,1,1,1,0,1,1,0,1,0,0,1};
      es = '{1,2,0,1,1,1,2,3,1,2,3,2,0,1};
      do_reset(2);
      for (int i = 0; i < 14; i++) begin
         apply(s[i], 1'b1);
         #1;
         exp_o = (i == 8);
         n_vec++;
         if (out_def !== exp_o) begin
            n_err++; $display("FAIL basic_out bit %0d: got %b want %b", i + 1, out_def, exp_o);
         end
         @(posedge clk); #1;
         n_vec++;
         if (st_def !== 2'(es[i])) begin
            n_err++; $display("FAIL basic_state bit %0d: got %0d want %0d", i + 1, st_def, es[i]);
         end
      end
      n_vec++;
      if (cnt_def !== 8'd1) begin
         n_err++; $display("FAIL basic_cnt: got %0d want 1", cnt_def);
      end
   endtask

   task automatic test_overlap();
      bit   s [7];
      int   es_def [7];
      int   es_nov [7];
      logic exp_d, exp_n;
      s      = '{1,0,1,1,0,1,1};
      es_def = '{1,2,3,1,2,3,1};
      es_nov = '{1,2,3,0,0,1,1};
      do_reset(2);
      for (int i = 0; i < 7; i++) begin
         apply(s[i], 1'b1);
         #1;
         exp_d = (i == 3) || (i == 6);
         exp_n = (i == 3);
         n_vec++;
         if (out_def !== exp_d || out_nov !== exp_n) begin
            n_err++;
            $display("FAIL overlap_out bit %0d: got ov=%b nov=%b want ov=%b nov=%b",
                     i + 1, out_def, out_nov, exp_d, exp_n);
         end
         @(posedge clk); #1;
         n_vec++;
         if (st_def !== 2'(es_def[i]) || st_nov !== 2'(es_nov[i])) begin
            n_err++;
            $display("FAIL overlap_state bit %0d: got ov=%0d nov=%0d want ov=%0d nov=%0d",
                     i + 1, st_def, st_nov, es_def[i], es_nov[i]);
         end
      end
      n_vec++;
      if (cnt_def !== 8'd2 || cnt_nov !== 8'd1) begin
         n_err++; $display("FAIL overlap_cnt: got ov=%0d nov=%0d want 2 1", cnt_def, cnt_nov);
      end
   endtask

   task automatic test_moore();
      bit   s [9];
      bit   v [9];
      logic exp_o;
      s = '{1,0,1,1,0,1,1,0,0};
      v = '{1,1,1,1,1,1,1,0,0};
      do_reset(2);
      for (int i = 0; i < 9; i++) begin
         apply(s[i], v[i]);
         #1;
         n_vec++;
         exp_o = (i == 4) || (i == 7);
         if (out_moo !== exp_o) begin
            n_err++; $display("FAIL moore_pre cycle %0d: got %b want %b", i + 1, out_moo, exp_o);
         end
         @(posedge clk); #1;
         exp_o = (i == 3) || (i == 6);
         n_vec++;
         if (out_moo !== exp_o) begin
            n_err++; $display("FAIL moore_out cycle %0d: got %b want %b", i + 1, out_moo, exp_o);
         end
      end
      n_vec++;
      if (cnt_moo !== 8'd2 || st_moo !== 2'd1) begin
         n_err++; $display("FAIL moore_cnt: cnt %0d state %0d want 2 1", cnt_moo, st_moo);
      end
   endtask

   task automatic test_gaps();
      bit s [4];
      int es [4];
      s  = '{1,0,1,1};
      es = '{1,2,3,1};
      do_reset(2);
      for (int k = 0; k < 4; k++) begin
         apply(s[k], 1'b1);
         #1;
         n_vec++;
         if (out_def !== (k == 3)) begin
            n_err++; $display("FAIL gaps_out bit %0d: got %b want %b", k + 1, out_def, (k == 3));
         end
         @(posedge clk); #1;
         n_vec++;
         if (st_def !== 2'(es[k]) || out_moo !== (k == 3)) begin
            n_err++;
            $display("FAIL gaps_state bit %0d: state %0d moore %b want %0d %b",
                     k + 1, st_def, out_moo, es[k], (k == 3));
         end
         for (int g = 0; g < 3; g++) begin
            apply(1'($urandom_range(0, 1)), 1'b0);
            #1;
            n_vec++;
            if (out_def !== 1'b0) begin
               n_err++; $display("FAIL gaps_idle_out bit %0d gap %0d: got %b want 0", k + 1, g, out_def);
            end
            @(posedge clk); #1;
            n_vec++;
            if (st_def !== 2'(es[k]) || out_moo !== 1'b0) begin
               n_err++;
               $display("FAIL gaps_hold bit %0d gap %0d: state %0d moore %b want %0d 0",
                        k + 1, g, st_def, out_moo, es[k]);
            end
         end
      end
      n_vec++;
      if (cnt_def !== 8'd1) begin
         n_err++; $display("FAIL gaps_cnt: got %0d want 1", cnt_def);
      end
   endtask

   task automatic test_reset_mid();
      do_reset(2);
      apply(1'b1, 1'b1);
      apply(1'b0, 1'b1);
      apply(1'b1, 1'b1);
      @(posedge clk); #1;
      n_vec++;
      if (st_def !== 2'd3) begin
         n_err++; $display("FAIL mid_prefix: got %0d want 3", st_def);
      end
      @(negedge clk);
      sync_reset = 1'b1;
      in_stream  = 1'b1;
      in_valid   = 1'b1;
      #1;
      n_vec++;
      if (out_def !== 1'b0) begin
         n_err++; $display("FAIL mid_reset_out: got %b want 0", out_def);
      end
      @(posedge clk); #1;
      n_vec++;
      if (st_def !== 2'd0 || cnt_def !== 8'd0) begin
         n_err++; $display("FAIL mid_reset_state: state %0d cnt %0d want 0 0", st_def, cnt_def);
      end
      @(negedge clk);
      sync_reset = 1'b0;
      in_stream  = 1'b1;
      #1;
      n_vec++;
      if (out_def !== 1'b0) begin
         n_err++; $display("FAIL mid_after_out: got %b want 0", out_def);
      end
      @(posedge clk); #1;
      n_vec++;
      if (st_def !== 2'd1 || cnt_def !== 8'd0) begin
         n_err++; $display("FAIL mid_after_state: state %0d cnt %0d want 1 0", st_def, cnt_def);
      end
   endtask

   task automatic test_saturate();
      bit   s [16];
      int   exp_sat [16];
      s       = '{1,0,1,1, 0,1,1, 0,1,1, 0,1,1, 0,1,1};
      exp_sat = '{0,0,0,1, 1,1,2, 2,2,3, 3,3,3, 3,3,3};
      do_reset(2);
      for (int i = 0; i < 16; i++) begin
         apply(s[i], 1'b1);
         @(posedge clk); #1;
         n_vec++;
         if (cnt_sat !== 2'(exp_sat[i])) begin
            n_err++; $display("FAIL sat_cnt bit %0d: got %0d want %0d", i + 1, cnt_sat, exp_sat[i]);
         end
      end
      n_vec++;
      if (cnt_def !== 8'd5) begin
         n_err++; $display("FAIL sat_wide_cnt: got %0d want 5", cnt_def);
      end
   endtask

   task automatic test_clear_on_match();
      bit s [6];
      s = '{1,0,1,1,0,1};
      do_reset(2);
      for (int i = 0; i < 6; i++) apply(s[i], 1'b1);
      @(posedge clk); #1;
      n_vec++;
      if (cnt_def !== 8'd1) begin
         n_err++; $display("FAIL clr_pre_cnt: got %0d want 1", cnt_def);
      end
      apply(1'b1, 1'b1);
      cnt_clr = 1'b1;
      #1;
      n_vec++;
      if (out_def !== 1'b1) begin
         n_err++; $display("FAIL clr_match_out: got %b want 1", out_def);
      end
      @(posedge clk); #1;
      n_vec++;
      if (cnt_def !== 8'd0 || st_def !== 2'd1) begin
         n_err++; $display("FAIL clr_match_cnt: cnt %0d state %0d want 0 1", cnt_def, st_def);
      end
      apply(1'b0, 1'b1);
      cnt_clr = 1'b0;
      apply(1'b1, 1'b1);
      apply(1'b1, 1'b1);
      @(posedge clk); #1;
      n_vec++;
      if (cnt_def !== 8'd1) begin
         n_err++; $display("FAIL clr_recount: got %0d want 1", cnt_def);
      end
   endtask

   task automatic test_pat6();
      bit   s [9];
      int   es [9];
      logic exp_o;
      s  = '{1,1,0,1,1,0,1,1,0};
      es = '{1,2,3,4,5,3,4,5,3};
      do_reset(2);
      for (int i = 0; i < 9; i++) begin
         apply(s[i], 1'b1);
         #1;
         exp_o = (i == 5) || (i == 8);
         n_vec++;
         if (out_p6 !== exp_o) begin
            n_err++; $display("FAIL p6_out bit %0d: got %b want %b", i + 1, out_p6, exp_o);
         end
         @(posedge clk); #1;
         n_vec++;
         if (st_p6 !== 3'(es[i])) begin
            n_err++; $display("FAIL p6_state bit %0d: got %0d want %0d", i + 1, st_p6, es[i]);
         end
      end
      n_vec++;
      if (cnt_p6 !== 8'd2) begin
         n_err++; $display("FAIL p6_cnt: got %0d want 2", cnt_p6);
      end
   endtask

   // sequence and report
   initial begin
      sync_reset = 1'b0;
      in_stream  = 1'b0;
      in_valid   = 1'b0;
      cnt_clr    = 1'b0;
      test_reset();
      test_basic();
      test_overlap();
      test_moore();
      test_gaps();
      test_reset_mid();
      test_saturate();
      test_clear_on_match();
      test_pat6();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
Parametrised serial bit-pattern detector, successor to the fixed 2-bit-state Mealy detector. It watches a 1-bit stream and flags each occurrence of a compile-time pattern of length PAT_LEN. Overlapping or non-overlapping matching and Mealy or Moore output timing are selectable by parameter, and a saturating match counter is included. It sits on the serial-input datapath and feeds match pulses and counts to control logic.

Parameters:
PAT_LEN, 4, pattern length in bits; legal range 2..16.
PATTERN, 4'b1011, pattern value, PAT_LEN bits wide; PATTERN[PAT_LEN-1] is the first bit received.
OVERLAP, 1, 1 = overlapping matches allowed; 0 = detector restarts from empty after each match.
MOORE, 0, 0 = Mealy output (combinational, same cycle as last bit); 1 = Moore output (registered, one cycle later).
CNT_W, 8, match counter width.

Ports:
clk  in  1  rising-edge clock
sync_reset  in  1  synchronous, active-high reset
in_stream  in  1  serial data bit
in_valid  in  1  in_stream is consumed on a clk edge only when 1
cnt_clr  in  1  synchronous clear of match_cnt
state  out  SW=max(1,$clog2(PAT_LEN))  current matched-prefix length, 0..PAT_LEN-1
out  out  1  match pulse
match_cnt  out  CNT_W  number of matches since reset/clear, saturating

Behaviour:
- Reset (sync_reset=1 at clk edge): state=0, match_cnt=0, Moore out register=0. While sync_reset=1, out=0 in both modes. sync_reset has priority over in_valid and cnt_clr. Reset mid-pattern discards the partial match.
- state is the length k of the longest proper prefix of PATTERN that equals the last k consumed bits. It is updated only on edges with in_valid=1 and held otherwise.
- Full match: a consumed bit completes PATTERN when state==PAT_LEN-1 and in_stream==PATTERN[0].
- Next state after a full match:
  - OVERLAP=1: the length of the longest proper border of PATTERN (KMP failure value). For 1011 this is 1.
  - OVERLAP=0: 0.
- Next state on a mismatch: the longest prefix that is a suffix of (matched prefix & in_stream). Falling back to 0 is forbidden when a shorter border still matches.
- Mealy (MOORE=0):
  - out = in_valid & ~sync_reset & full-match condition. Purely combinational, asserted in the same cycle as the last bit.
  - out=0 whenever in_valid=0.
- Moore (MOORE=1):
  - out is a register set to 1 on the edge that consumes the completing bit, and held for exactly one cycle.
  - Back-to-back matches (possible only with PAT_LEN's border plus 1 bit) give consecutive high cycles.
  - out falls to 0 on the next edge if no new match occurs, regardless of in_valid.
- match_cnt:
  - Increments by 1 on the edge that consumes a completing bit.
  - Saturates at 2^CNT_W-1; no wrap.
  - cnt_clr=1 forces it to 0 on that edge; cnt_clr wins over a simultaneous match.
  - Counting is identical in both modes.
- Latency: Mealy 0 cycles after the last bit is presented; Moore 1 cycle after the consuming edge.
- Elaboration must fail (or $error) if PAT_LEN<2 or PAT_LEN>16.

Test Plan:
1. Defaults (1011, OVERLAP=1, Mealy), reset 5 cycles, then stream 1,0,0,1,1,1,0,1,1,0,1,0,0,1 with in_valid=1 -> exactly one out pulse, coincident with the 9th bit. match_cnt=1. state sequence 1,2,0,1,1,1,2,3,1,2,3,2,0,1.
2. Overlap: stream 1,0,1,1,0,1,1 -> OVERLAP=1 gives pulses on bits 4 and 7 and match_cnt=2. OVERLAP=0 gives one pulse on bit 4, match_cnt=1, and state=0 after bit 4.
3. MOORE=1, stream from scenario 2 -> out high the cycle after bits 4 and 7 were consumed. Each pulse is one cycle wide.
4. in_valid gaps: stream 1,0,1,1 with in_valid=0 for 3 cycles between each bit (in_stream toggled randomly while invalid) -> state holds during gaps. Single match on the 4th valid bit. out=0 in all invalid cycles.
5. Reset/clear:
   - sync_reset=1 after the 3 bits 1,0,1; then stream 1 -> no match, state=1.
   - CNT_W=2 with 5 matches -> match_cnt saturates at 3.
   - cnt_clr asserted on the same edge as a match -> match_cnt=0.
6. PAT_LEN=6, PATTERN=6'b110110, OVERLAP=1, stream 1,1,0,1,1,0,1,1,0 -> pulses on bits 6 and 9 (border 3). match_cnt=2.
